// File: rtl/uart_eia232_core.sv
// uart_eia232_core: SUMP-style RS-232 host link.
// Contains a baud tick prescaler, an 8N1 receiver with command assembly,
// local opcode decode and an 8N1 transmitter for 32-bit sample words.
// Optional feature macro: UART_XONXOFF_EN (XON/XOFF pauses the transmitter).
module uart_eia232_core #(
  parameter int FREQ  = 100000000,
  parameter int SCALE = 28,
  parameter int RATE  = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  speed,
  input  logic        send,
  input  logic [31:0] wrdata,
  input  logic        rx,
  output logic        tx,
  output logic [39:0] cmd,
  output logic        execute,
  output logic        busy
);
  localparam int TRXFREQ = FREQ / SCALE;
  localparam int BITLEN  = TRXFREQ / RATE;
  localparam int HALF    = BITLEN / 2;
  localparam int CW      = $clog2(BITLEN + 1);
  localparam int PW      = $clog2(SCALE * 6 + 1);

  // ---------------- prescaler ----------------
  logic [PW-1:0] pre_cnt, pre_lim;
  logic          tick;

  // divide limit by speed; >= compare keeps a speed change from locking up
  always_comb begin
    unique case (speed)
      2'b00:   pre_lim = PW'(SCALE - 1);
      2'b01:   pre_lim = PW'(SCALE * 2 - 1);
      2'b10:   pre_lim = PW'(SCALE * 3 - 1);
      default: pre_lim = PW'(SCALE * 6 - 1);
    endcase
  end

  // one-cycle tick every pre_lim+1 clocks
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt >= pre_lim) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  rx_state_t     rx_state;
  logic          rx_meta, rx_s, rx_last;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid;

  // two-flop synchroniser on the asynchronous serial input
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // 8N1 receive FSM; start needs a high->low edge so a framing error
  // with the line still low cannot re-trigger a bogus frame
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= R_IDLE;
      rx_last  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (tick) begin
        rx_last <= rx_s;
        unique case (rx_state)
          R_IDLE: if (!rx_s && rx_last) begin
            rx_state <= R_START;
            rx_cnt   <= '0;
          end
          R_START: if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? R_IDLE : R_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
          R_DATA: if (rx_cnt == CW'(BITLEN - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= R_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
          default: if (rx_cnt == CW'(BITLEN - 1)) begin
            rx_cnt   <= '0;
            rx_state <= R_IDLE;
            if (rx_s) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end
          end else rx_cnt <= rx_cnt + 1'b1;
        endcase
      end
    end
  end

  // ---------------- command assembly ----------------
  logic [2:0]  asm_idx;
  logic [7:0]  opcode;
  logic [23:0] data;

  // byte 0 is the opcode; long commands collect 4 little-endian data bytes
  always_ff @(posedge clock) begin
    if (reset) begin
      asm_idx <= '0;
      opcode  <= '0;
      data    <= '0;
      cmd     <= '0;
      execute <= 1'b0;
    end else begin
      execute <= 1'b0;
      if (rx_valid) begin
        if (asm_idx == 3'd0) begin
          opcode <= rx_byte;
          data   <= '0;
          if (!rx_byte[7]) begin
            cmd     <= {32'h0, rx_byte};
            execute <= 1'b1;
          end else asm_idx <= 3'd1;
        end else begin
          unique case (asm_idx)
            3'd1: data[7:0]   <= rx_byte;
            3'd2: data[15:8]  <= rx_byte;
            3'd3: data[23:16] <= rx_byte;
            default: begin
              cmd     <= {rx_byte, data, opcode};
              execute <= 1'b1;
            end
          endcase
          asm_idx <= (asm_idx == 3'd4) ? 3'd0 : asm_idx + 1'b1;
        end
      end
    end
  end

  // ---------------- local decode ----------------
  logic       id_req;
  logic [3:0] dis_groups;
  logic       hold;

  // ID request pulse and byte-group disable flags, one cycle after execute
  always_ff @(posedge clock) begin
    if (reset) begin
      id_req     <= 1'b0;
      dis_groups <= '0;
    end else begin
      id_req <= execute && (cmd[7:0] == 8'h02);
      if (execute && cmd[7:0] == 8'h82) dis_groups <= cmd[13:10];
    end
  end

`ifdef UART_XONXOFF_EN
  logic xoff;
  // XOFF pauses the transmitter between frames until XON arrives
  always_ff @(posedge clock) begin
    if (reset) xoff <= 1'b0;
    else if (execute && cmd[7:0] == 8'h11) xoff <= 1'b0;
    else if (execute && cmd[7:0] == 8'h13) xoff <= 1'b1;
  end
  assign hold = xoff;
`else
  assign hold = 1'b0;
`endif

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {T_IDLE, T_LOAD, T_START, T_DATA, T_STOP} tx_state_t;
  tx_state_t     tx_state;
  logic [31:0]   word;
  logic [3:0]    pend;
  logic [7:0]    tx_shift, nxt_byte;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [1:0]    nxt;

  // lowest pending byte group is the next one on the wire
  always_comb begin
    nxt = 2'd0;
    for (int i = 3; i >= 0; i--) if (pend[i]) nxt = 2'(i);
    nxt_byte = word[{nxt, 3'b000} +: 8];
  end

  // 8N1 transmit FSM; frames start on a tick so every bit is BITLEN ticks
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= T_IDLE;
      word     <= '0;
      pend     <= '0;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      unique case (tx_state)
        T_IDLE: if (send) begin
          word     <= wrdata;
          pend     <= ~dis_groups;
          busy     <= 1'b1;
          tx_state <= T_LOAD;
        end else if (id_req) begin
          word     <= 32'h534C4131;
          pend     <= 4'hF;
          busy     <= 1'b1;
          tx_state <= T_LOAD;
        end
        T_LOAD: if (pend == 4'h0) begin
          busy     <= 1'b0;
          tx_state <= T_IDLE;
        end else if (!hold && tick) begin
          tx_shift  <= nxt_byte;
          pend[nxt] <= 1'b0;
          tx        <= 1'b0;
          tx_cnt    <= '0;
          tx_state  <= T_START;
        end
        T_START: if (tick) begin
          if (tx_cnt == CW'(BITLEN - 1)) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= T_DATA;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        T_DATA: if (tick) begin
          if (tx_cnt == CW'(BITLEN - 1)) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= T_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
            end
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        default: if (tick) begin
          if (tx_cnt == CW'(BITLEN - 1)) begin
            tx_cnt <= '0;
            if (pend == 4'h0) begin
              busy     <= 1'b0;
              tx_state <= T_IDLE;
            end else if (hold) begin
              tx_state <= T_LOAD;
            end else begin
              tx_shift  <= nxt_byte;
              pend[nxt] <= 1'b0;
              tx        <= 1'b0;
              tx_state  <= T_START;
            end
          end else tx_cnt <= tx_cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_eia232_core.sv
// Testbench for uart_eia232_core. Runs with a scaled-down clock/baud
// (BITLEN = 7 ticks, 4 clk/tick -> 28 clk/bit at speed 00) to keep runs short.
module tb_uart_eia232_core;
  localparam int FREQ = 2800000, SCALE = 4, RATE = 100000;
  localparam int BITLEN = (FREQ / SCALE) / RATE;

  logic        clock = 1'b0, reset = 1'b1, send = 1'b0, rx = 1'b1;
  logic [1:0]  speed = 2'b00;
  logic [31:0] wrdata = '0;
  logic        tx, execute, busy;
  logic [39:0] cmd;

  uart_eia232_core #(.FREQ(FREQ), .SCALE(SCALE), .RATE(RATE)) dut (
    .clock(clock), .reset(reset), .speed(speed), .send(send), .wrdata(wrdata),
    .rx(rx), .tx(tx), .cmd(cmd), .execute(execute), .busy(busy));

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0, n_exec = 0;
  int bitclk = SCALE * BITLEN;
  bit mon_en = 1'b0;
  logic [7:0]  exp_tx[$];
  logic [39:0] exp_cmd[$];

  typedef struct {
    int          n;
    logic [39:0] bytes;
    logic [39:0] exp;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one 8N1 frame on rx, then one idle bit
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (bitclk) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bitclk) @(negedge clock);
    end
    rx = stop_bit;
    repeat (bitclk) @(negedge clock);
    rx = 1'b1;
    repeat (bitclk) @(negedge clock);
  endtask

  task automatic pulse_send(input logic [31:0] w);
    wrdata = w;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((exp_tx.size() != 0 || exp_cmd.size() != 0 || busy !== 1'b0) && t < 20000) begin
      @(negedge clock);
      t++;
    end
    chk(name, 64'(t >= 20000), 64'd0);
    repeat (bitclk) @(negedge clock);
  endtask

  // execute scoreboard: each pulse pops the expected command
  always @(negedge clock) begin
    if (!reset && execute === 1'b1) begin
      n_exec++;
      if (exp_cmd.size() == 0) chk("unexpected execute cmd", 64'(cmd), 64'hFFFF_FFFF_FFFF);
      else chk("cmd", 64'(cmd), 64'(exp_cmd.pop_front()));
    end
  end

  // tx scoreboard: decode frames mid-bit and pop the expected byte
  logic tx_prev = 1'b1;
  always begin
    logic [7:0] b;
    logic       st, sp;
    @(negedge clock);
    if (mon_en && tx_prev === 1'b1 && tx === 1'b0) begin
      repeat (bitclk / 2) @(negedge clock);
      st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (bitclk) @(negedge clock);
        b[i] = tx;
      end
      repeat (bitclk) @(negedge clock);
      sp = tx;
      if (mon_en) begin
        chk("tx start bit", 64'(st), 64'd0);
        chk("tx stop bit", 64'(sp), 64'd1);
        if (exp_tx.size() == 0) chk("unexpected tx byte", 64'(b), 64'h1FF);
        else chk("tx byte", 64'(b), 64'(exp_tx.pop_front()));
      end
    end
    tx_prev = tx;
  end

  // every low run on tx must be a whole number of bit periods
  int low_run = 0;
  always @(negedge clock) begin
    if (tx === 1'b0) low_run++;
    else begin
      if (low_run > 0 && mon_en) chk("tx low run % bit period", 64'(low_run % bitclk), 64'd0);
      low_run = 0;
    end
  end

  initial begin
    int e0, bc;
    tbl[0] = '{1, 40'h00,         40'h0000000000};
    tbl[1] = '{1, 40'h7F,         40'h000000007F};
    tbl[2] = '{5, 40'hDDCCBBAA80, 40'hDDCCBBAA80};
    tbl[3] = '{5, 40'h0403020181, 40'h0403020181};

    // reset and idle
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    chk("reset tx", 64'(tx), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset execute", 64'(execute), 64'd0);
    chk("reset cmd", 64'(cmd), 64'd0);
    mon_en = 1'b1;

    // short and long commands from the table
    for (int v = 0; v < 4; v++) begin
      e0 = n_exec;
      exp_cmd.push_back(tbl[v].exp);
      for (int k = 0; k < tbl[v].n; k++) rx_frame(tbl[v].bytes[8*k +: 8], 1'b1);
      wait_done("table cmd timeout");
      chk("table execute count", 64'(n_exec - e0), 64'd1);
    end

    // ID request answered with "1ALS"
    exp_cmd.push_back(40'h02);
    exp_tx.push_back(8'h31); exp_tx.push_back(8'h41);
    exp_tx.push_back(8'h4C); exp_tx.push_back(8'h53);
    rx_frame(8'h02, 1'b1);
    wait_done("id timeout");

    // groups 0,1 disabled -> only 0x33,0x44 go out
    exp_cmd.push_back(40'h0000000C82);
    rx_frame(8'h82, 1'b1); rx_frame(8'h0C, 1'b1);
    rx_frame(8'h00, 1'b1); rx_frame(8'h00, 1'b1); rx_frame(8'h00, 1'b1);
    wait_done("flags cmd timeout");
    exp_tx.push_back(8'h33); exp_tx.push_back(8'h44);
    pulse_send(32'h44332211);
    chk("busy after send", 64'(busy), 64'd1);
    wait_done("flags send timeout");

    // all groups disabled -> busy exactly one cycle, no frames
    exp_cmd.push_back(40'h0000003C82);
    rx_frame(8'h82, 1'b1); rx_frame(8'h3C, 1'b1);
    rx_frame(8'h00, 1'b1); rx_frame(8'h00, 1'b1); rx_frame(8'h00, 1'b1);
    wait_done("all-off cmd timeout");
    pulse_send(32'h44332211);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) bc++;
      @(negedge clock);
    end
    chk("busy cycles all disabled", 64'(bc), 64'd1);
    exp_cmd.push_back(40'h0000000082);
    rx_frame(8'h82, 1'b1); rx_frame(8'h00, 1'b1);
    rx_frame(8'h00, 1'b1); rx_frame(8'h00, 1'b1); rx_frame(8'h00, 1'b1);
    wait_done("flags clear timeout");

    // XOFF during byte 0, then XON
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
    exp_tx.push_back(8'h33); exp_tx.push_back(8'h44);
    exp_cmd.push_back(40'h13);
    pulse_send(32'h44332211);
    rx_frame(8'h13, 1'b1);
`ifdef UART_XONXOFF_EN
    repeat (2 * bitclk) @(negedge clock);
    chk("xoff bytes left", 64'(exp_tx.size()), 64'd3);
    repeat (10 * bitclk) @(negedge clock);
    chk("xoff tx held", 64'(tx), 64'd1);
    chk("xoff busy", 64'(busy), 64'd1);
    chk("xoff still held", 64'(exp_tx.size()), 64'd3);
`endif
    exp_cmd.push_back(40'h11);
    rx_frame(8'h11, 1'b1);
    wait_done("xon timeout");

    // framing error discarded, next command accepted
    e0 = n_exec;
    rx_frame(8'h55, 1'b0);
    repeat (4 * bitclk) @(negedge clock);
    chk("framing error no execute", 64'(n_exec - e0), 64'd0);
    exp_cmd.push_back(40'h02);
    exp_tx.push_back(8'h31); exp_tx.push_back(8'h41);
    exp_tx.push_back(8'h4C); exp_tx.push_back(8'h53);
    rx_frame(8'h02, 1'b1);
    wait_done("post-error id timeout");

    // half speed
    speed = 2'b01;
    bitclk = 2 * SCALE * BITLEN;
    repeat (bitclk) @(negedge clock);
    exp_cmd.push_back(40'h00);
    rx_frame(8'h00, 1'b1);
    wait_done("speed01 cmd timeout");
    exp_cmd.push_back(40'h02);
    exp_tx.push_back(8'h31); exp_tx.push_back(8'h41);
    exp_tx.push_back(8'h4C); exp_tx.push_back(8'h53);
    rx_frame(8'h02, 1'b1);
    wait_done("speed01 id timeout");
    speed = 2'b00;
    bitclk = SCALE * BITLEN;
    repeat (bitclk) @(negedge clock);

    // reset mid-frame and mid-command
    mon_en = 1'b0;
    pulse_send(32'h00000000);
    rx_frame(8'h80, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("reset mid-frame tx", 64'(tx), 64'd1);
    chk("reset mid-frame busy", 64'(busy), 64'd0);
    reset = 1'b0;
    repeat (12 * bitclk) @(negedge clock);
    tx_prev = 1'b1;
    mon_en = 1'b1;
    exp_cmd.push_back(40'h05);
    rx_frame(8'h05, 1'b1);
    wait_done("post-reset cmd timeout");

    chk("cmd queue empty", 64'(exp_cmd.size()), 64'd0);
    chk("tx queue empty", 64'(exp_tx.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
